down_counter_timer: RTL and testbench
=====================================

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter and load-value width in bits.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Port load  input  1  SHALL copy load_val into the counter and the reload register.
REQ-005 Port load_val  input  WIDTH  SHALL be the initial/reload count.
REQ-006 Port start  input  1  SHALL request counting.
REQ-007 Port stop  input  1  SHALL request a pause that holds the count.
REQ-008 Port auto_reload  input  1  SHALL select periodic (1) or one-shot (0) mode, sampled every cycle.
REQ-009 Port q  output  WIDTH  SHALL be the registered count value.
REQ-010 Port busy  output  1  SHALL be high exactly while the state is RUN.
REQ-011 Port done  output  1  SHALL be high exactly while the state is DONE.
REQ-012 Port tc  output  1  SHALL be a registered one-cycle terminal-count pulse.

Function
REQ-013 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-014 Counting SHALL be synchronous, with all bits updating on the same clk edge; ripple clocking SHALL NOT be used.
REQ-015 When load=1 in any state, the block SHALL set q<=load_val and reload_reg<=load_val, and the next state SHALL be IDLE.
REQ-016 load SHALL take priority over start, stop and counting.
REQ-017 In IDLE or DONE, start=1 with q!=0 SHALL move the state to RUN with q unchanged on that edge.
REQ-018 In IDLE or DONE, start=1 with q==0 SHALL be ignored, and the state SHALL be held.
REQ-019 In RUN with q>1, each edge SHALL perform q<=q-1.
REQ-020 In RUN with q==1 and auto_reload=0, the edge SHALL perform q<=0, tc<=1 and state<=DONE.
REQ-021 In RUN with q==1 and auto_reload=1, the edge SHALL perform q<=reload_reg, tc<=1 and stay in RUN; the period SHALL be reload_reg cycles.
REQ-022 In RUN with auto_reload=1 and reload_reg==1, tc SHALL be high every cycle.
REQ-023 tc SHALL be 0 on every edge not covered by REQ-020 or REQ-021, so it is never high for two cycles except under REQ-022.
REQ-024 In RUN, stop=1 SHALL move the state to IDLE and hold q; a later start SHALL resume from the held q.
REQ-025 When start and stop are asserted together, stop SHALL take priority.
REQ-026 q SHALL never wrap below 0 or above the loaded value.
REQ-027 busy and done SHALL be decoded from the state register only, with no input-to-output combinational path.

Reset
REQ-028 While reset=1, the block SHALL immediately force q=0, reload_reg=0, tc=0, busy=0, done=0 and state=IDLE, independent of clk.
REQ-029 The first edge after reset deasserts SHALL obey the Function rules using the reset values.
REQ-030 Reset asserted during RUN SHALL abort the count, with no tc pulse.

Verification
REQ-031 One-shot bench: load_val=5 with load at edge 0, start at edge 1 -> q SHALL be 4,3,2,1,0 at edges 2-6, tc=1 only in the cycle after edge 6, then done=1 and busy=0.
REQ-032 Periodic bench: load 3, auto_reload=1, start -> q SHALL follow 3,2,1,3,2,1..., with tc high once every 3 cycles and busy held at 1.
REQ-033 Pause bench: load 8, start, stop once q=5, hold 4 cycles, then start -> q SHALL stay 5 while paused, then count 4,3,...,0.
REQ-034 Priority bench: load and start in the same cycle SHALL give IDLE with q=load_val; start+stop together in IDLE SHALL give no RUN; start with q=0 SHALL be ignored.
REQ-035 Reset bench: load 10, start, assert reset mid-run between edges -> q=0, busy=0, done=0 and tc=0 SHALL hold before the next edge.
REQ-036 Width bench: WIDTH=8 with load 255, one-shot -> done SHALL assert exactly 255 edges after the start edge, with a single tc pulse.

Source files
------------

// File: rtl/down_counter_timer.sv
// Down-counting timer with load, start/stop control and optional periodic reload.
// A three-state FSM (IDLE/RUN/DONE) sequences a synchronous down counter.
// A registered one-cycle terminal-count pulse fires on the 1 -> 0 (or 1 -> reload) edge.

module down_counter_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             tc_q;
    logic             tc_d;

    logic             count_zero;
    logic             count_one;
    logic             run_step;
    logic             terminal;

    // Count decodes shared by the FSM and the datapath.
    always_comb begin
        count_zero = (count_q == '0);
        count_one  = (count_q == WIDTH'(1));
        // A counting edge: in RUN, not loading, not pausing.
        run_step   = (state_q == StRun) && !load && !stop;
        terminal   = run_step && count_one;
    end

    // State register; reset aborts any count in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: load beats everything, stop beats start.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    // A zero count cannot be started; the state is simply held.
                    if (start && !stop && !count_zero) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StIdle;
                    end else if (count_zero) begin
                        // Unreachable in normal use; settle rather than underflow.
                        state_d = StDone;
                    end else if (count_one && !auto_reload) begin
                        state_d = StDone;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Datapath next-state: counter, reload register and terminal-count pulse.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
        end else if (terminal) begin
            tc_d    = 1'b1;
            count_d = auto_reload ? reload_q : '0;
        end else if (run_step && !count_zero) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Datapath registers, all updated on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Outputs decoded purely from registers; no input-to-output path.
    always_comb begin
        q    = count_q;
        tc   = tc_q;
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed vector table, hand-written
// corner sequences and randomized stimulus checked against a behavioural model.

module tb_down_counter_timer;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         tc;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: remaining count, reload value, running/finished flags.
    int m_q;
    int m_rl;
    bit m_run;
    bit m_fin;
    bit m_tc;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int eq, input int eb, input int ed,
                             input int et);
        check({tag, ".q"}, 32'(q), eq);
        check({tag, ".busy"}, 32'(busy), eb);
        check({tag, ".done"}, 32'(done), ed);
        check({tag, ".tc"}, 32'(tc), et);
    endtask

    function automatic void model_reset();
        m_q   = 0;
        m_rl  = 0;
        m_run = 0;
        m_fin = 0;
        m_tc  = 0;
    endfunction

    // One clock edge of the timer, described by what the timer is meant to do.
    function automatic void model_step(bit ld, int lv, bit st, bit sp, bit ar);
        m_tc = 0;
        if (ld) begin
            m_q   = lv;
            m_rl  = lv;
            m_run = 0;
            m_fin = 0;
        end else if (m_run) begin
            if (sp) begin
                m_run = 0;
            end else if (m_q == 0) begin
                m_run = 0;
                m_fin = 1;
            end else begin
                m_q = m_q - 1;
                if (m_q == 0) begin
                    m_tc = 1;
                    if (ar) m_q = m_rl;
                    else begin
                        m_run = 0;
                        m_fin = 1;
                    end
                end
            end
        end else if (st && !sp && m_q != 0) begin
            m_run = 1;
            m_fin = 0;
        end
    endfunction

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic apply(input bit ld, input int lv, input bit st, input bit sp, input bit ar);
        load        = ld;
        load_val    = W'(lv);
        start       = st;
        stop        = sp;
        auto_reload = ar;
        @(posedge clk);
        #1;
        model_step(ld, lv, st, sp, ar);
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_q, int'(m_run), int'(m_fin), int'(m_tc));
    endtask

    typedef struct {
        bit ld;
        int lv;
        bit st;
        bit sp;
        bit ar;
        int eq;
        bit eb;
        bit ed;
        bit et;
    } vec_t;

    vec_t vecs[21];

    initial begin
        int edges;
        int tcs;

        // ld lv st sp ar | q busy done tc
        vecs[0]  = '{1, 5, 0, 0, 0, 5, 0, 0, 0};   // load 5
        vecs[1]  = '{0, 0, 1, 0, 0, 5, 1, 0, 0};   // start: q unchanged
        vecs[2]  = '{0, 0, 0, 0, 0, 4, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 3, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 2, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};   // terminal count, one-shot
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};   // tc drops, done held
        vecs[8]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0};   // start with q==0 ignored
        vecs[9]  = '{1, 7, 1, 0, 0, 7, 0, 0, 0};   // load beats start
        vecs[10] = '{0, 0, 1, 1, 0, 7, 0, 0, 0};   // stop beats start in IDLE
        vecs[11] = '{0, 0, 1, 0, 0, 7, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 1, 0, 7, 0, 0, 0};   // stop in RUN holds q
        vecs[13] = '{0, 0, 1, 0, 0, 7, 1, 0, 0};   // resume
        vecs[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};   // load zero mid-run
        vecs[15] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};   // start with q==0 ignored
        vecs[16] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
        vecs[17] = '{0, 0, 1, 0, 1, 1, 1, 0, 0};
        vecs[18] = '{0, 0, 0, 0, 1, 1, 1, 0, 1};   // reload of 1: tc every cycle
        vecs[19] = '{0, 0, 0, 0, 1, 1, 1, 0, 1};
        vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};   // one-shot again ends in DONE

        reset       = 1'b1;
        load        = 1'b0;
        load_val    = '0;
        start       = 1'b0;
        stop        = 1'b0;
        auto_reload = 1'b0;
        model_reset();
        #12;
        check_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 21; i++) begin
            apply(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].ar);
            check_all($sformatf("vec%0d", i), vecs[i].eq, int'(vecs[i].eb), int'(vecs[i].ed),
                      int'(vecs[i].et));
        end

        // Periodic: load 3 then q cycles 3,2,1,3,... with tc on each reload.
        apply(1, 3, 0, 0, 1);
        apply(0, 0, 1, 0, 1);
        check_all("per_start", 3, 1, 0, 0);
        for (int k = 0; k < 9; k++) begin
            apply(0, 0, 0, 0, 1);
            check_all($sformatf("per%0d", k), 3 - ((k + 1) % 3), 1, 0,
                      int'(((k + 1) % 3) == 0));
        end

        // Pause: load 8, count to 5, stop, hold 4 cycles, resume to 0.
        apply(1, 8, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) apply(0, 0, 0, 0, 0);
        check_all("pause_pre", 5, 1, 0, 0);
        apply(0, 0, 0, 1, 0);
        check_all("pause_stop", 5, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 0, 0, 0);
            check_all($sformatf("pause_hold%0d", k), 5, 0, 0, 0);
        end
        apply(0, 0, 1, 0, 0);
        check_all("pause_resume", 5, 1, 0, 0);
        for (int k = 4; k >= 0; k--) begin
            apply(0, 0, 0, 0, 0);
            check_all($sformatf("pause_cnt%0d", k), k, int'(k != 0), int'(k == 0),
                      int'(k == 0));
        end

        // Reset mid-run between edges takes effect before the next edge.
        apply(1, 10, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) apply(0, 0, 0, 0, 0);
        check_all("rst_pre", 7, 1, 0, 0);
        reset = 1'b1;
        #2;
        check_all("rst_async", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply(0, 0, 1, 0, 0);
        check_all("rst_after", 0, 0, 0, 0);

        // Full width one-shot: done exactly 255 edges after the start edge.
        apply(1, 255, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        edges = 0;
        tcs   = 0;
        for (int k = 0; k < 300; k++) begin
            apply(0, 0, 0, 0, 0);
            edges++;
            if (tc === 1'b1) tcs++;
            if (done === 1'b1) break;
        end
        check("wide_edges", 32'(edges), 255);
        check("wide_tcs", 32'(tcs), 1);
        check("wide_busy", 32'(busy), 0);

        // Randomized stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            bit ld;
            bit st;
            bit sp;
            bit ar;
            int lv;
            ld = ($urandom_range(0, 19) == 0);
            lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 6));
            st = ($urandom_range(0, 2) == 0);
            sp = ($urandom_range(0, 9) == 0);
            ar = 1'($urandom_range(0, 1));
            apply(ld, lv, st, sp, ar);
            check_model($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
